clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Run controller for the programmable clock divider. Holds the divide ratio and a period budget, starts and stops the divided output `f_out` on request, and applies new ratios only at period boundaries so the output never glitches. Sits between the register/config side (valid/ready) and the consumers of the divided clock enable.

## Interface

Parameters:
- `CNT_W`, 16: width of divisor and in-period counter.
- `PER_W`, 16: width of period budget and period counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config accept; handshake = `cfg_valid & cfg_ready` at a clock edge.
- `cfg_div`  in  CNT_W  divide ratio; 0 and 1 are treated as 2.
- `cfg_periods`  in  PER_W  output periods to run; 0 = free-run.
- `start`  in  1  level, sampled each edge; begins a run from IDLE.
- `stop`  in  1  level, sampled each edge; ends a run at the next period boundary.
- `f_out`  out  1  divided output, registered.
- `tick`  out  1  one-cycle pulse on every cycle `f_out` rises.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse on the first IDLE cycle after a run ends.

## Operation

- **States:** IDLE, RUN, STOPPING.
- **Active registers:** `div_q` (reset 2), `per_q` (reset 0). Shadow registers `div_p`, `per_p` with `pend` flag (reset 0).
- **IDLE:**
  - `cfg_ready=1`; a handshake loads `div_q` and `per_q` directly.
  - `start=1 & stop=0` → RUN; `cnt=0`, `per_cnt=0`.
  - `start & stop` together → stay IDLE, no `done`.
  - `stop` alone is ignored.
- **RUN:**
  - `cnt` counts 0..`div_q`-1 and wraps. The cycle with `cnt==div_q-1` is the boundary.
  - `f_out=1` while `cnt < div_q/2` (integer divide), else 0. Examples: div=2 → 10, div=3 → 100, div=4 → 1100.
  - `tick=1` when `cnt==0`.
  - At each boundary `per_cnt` increments. If `per_q!=0` and `per_cnt+1==per_q` → IDLE.
  - `start` is ignored.
- **Runtime reconfig:**
  - In RUN/STOPPING, `cfg_ready = ~pend`. A handshake fills the shadow registers and sets `pend`.
  - At the next boundary strictly after the handshake cycle: `div_q←div_p`, `per_q←per_p`, `per_cnt←0`, `pend←0`.
  - A handshake on a boundary cycle waits for the following boundary.
- **Stop:**
  - `stop` in RUN → STOPPING. The current period completes, then IDLE at the boundary.
  - A pending config is applied to the active registers at that same boundary.
  - `stop` on a boundary cycle → IDLE directly.
- **Run end:** on any run end, `done` pulses in the first IDLE cycle. `f_out` is already 0 there, because the last period cycle is always low phase.
- **Reset (`rst=0`, any time):**
  - State IDLE; `cnt=0`, `per_cnt=0`, `pend=0`, `div_q=2`, `per_q=0`.
  - Outputs: `f_out=0`, `tick=0`, `busy=0`, `done=0`, `cfg_ready=1`.
  - All outputs take these values immediately, without waiting for a clock edge.

## Timing

- **Start:** sampled at edge E; `busy`, `f_out` and `tick` are 1 in the cycle after E.
- **Period length:** exactly `div_q` cycles (min 2). A run of P periods is P·`div_q` cycles of `busy`.
- **Done:** pulses in the cycle after the final boundary; `busy=0` in that same cycle.
- **Back-to-back:** `start` held high through the `done` cycle begins a new run on the next edge (one IDLE cycle minimum).
- **Config:** IDLE load is visible the cycle after the handshake.
- **Width:** `cnt`/`div_q` use CNT_W and `per_cnt` uses PER_W; no overflow, since `per_cnt` is compared before increment. In free-run `per_cnt` wraps harmlessly.

## Structure

- **Package `clk_div_pkg`:**
  - state enum `{IDLE, RUN, STOPPING}`.
  - `MIN_DIV = 2`.
  - clamp function `eff_div(d) = (d < MIN_DIV) ? MIN_DIV : d`.
- **Sub-module `clk_div_core`:**
  - Inputs: `clk`, `rst`, `en`, `div`.
  - Outputs: `f_out`, `tick`, `boundary`.
  - Owns `cnt` and phase compare.
- **`clk_div_ctrl`:** owns the FSM, shadow/pending logic, `per_cnt`, `done`.

## Test plan

- **Reset:** release → `f_out=0`, `busy=0`, `cfg_ready=1`. Drop `rst` mid-RUN → all outputs at reset values immediately; `div_q` back to 2.
- **Counted run:** config div=4, periods=3; `start` → `f_out` = 1100 ×3, 3 `tick` pulses, `busy` 12 cycles, `done` in cycle 13.
- **Stop mid-period:** div=5, free-run; `stop` in RUN cycle 7 → `f_out` finishes the second period (low through cycle 10), IDLE and `done` in cycle 11.
- **Reconfig mid-period:** div=4 running; handshake div=2 in cnt=1 → `cfg_ready=0` until the boundary, current period 1100, then 1010…; a second `cfg_valid` is held off until `pend` clears.
- **Clamp:** div=0 and div=1, periods=2 → `f_out` = 1010, `done` after 4 cycles.
- **Simultaneous events:** `start & stop` in IDLE → stays IDLE, no `done`. Handshake on a boundary cycle → new div takes effect one period later.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
//   state_e  : run-controller FSM states
//   MIN_DIV  : smallest divide ratio that yields a real high/low output
//   eff_div  : clamps a requested ratio up to MIN_DIV
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned eff_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration valid/ready channel of the clock divider controller.
//   cfg_valid   : config offer (master -> slave)
//   cfg_ready   : config accept (slave -> master)
//   cfg_div     : requested divide ratio
//   cfg_periods : output periods to run, 0 = free-run
interface clk_div_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PER_W = 16
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [PER_W-1:0] cfg_periods;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_periods,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_periods,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_core.sv
// In-period counter and phase compare of the clock divider.
//   clk, rst : clock, asynchronous active-low reset
//   en       : divider is running in the coming cycle
//   div      : clamped ratio in effect in the coming cycle
//   f_out    : registered divided output, high while cnt < div/2
//   tick     : registered pulse on the first cycle of each period
//   boundary : current cycle is the last of its period
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             f_out,
  output logic             tick,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q;
  logic             run_q;

  assign boundary = run_q & (cnt_q == div_q - CNT_W'(1));

  // A run always begins at cnt=0; the counter restarts on every boundary.
  always_comb begin
    cnt_d = '0;
    if (en && run_q && !boundary) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // en/div describe the next cycle, so f_out and tick are true flops
  // computed from the next count rather than decoded after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      div_q <= CNT_W'(MIN_DIV);
      run_q <= 1'b0;
      f_out <= 1'b0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div;
      run_q <= en;
      f_out <= en & (cnt_d < (div >> 1));
      tick  <= en & (cnt_d == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run controller for the programmable clock divider.
//   clk, rst    : clock, asynchronous active-low reset
//   cfg         : config valid/ready channel (divide ratio, period budget)
//   start, stop : run requests, sampled as levels on each edge
//   f_out, tick : divided output and its rising-cycle pulse
//   busy        : a run is in progress
//   done        : pulse on the first idle cycle after a run
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PER_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_ctrl_if.slave  cfg,
  input  logic           start,
  input  logic           stop,
  output logic           f_out,
  output logic           tick,
  output logic           busy,
  output logic           done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d, div_p_q, div_p_d;
  logic [PER_W-1:0] per_q, per_d, per_p_q, per_p_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             pend_q, pend_d;
  logic             done_d;
  logic             hs, boundary, last_period, core_en;
  logic [CNT_W-1:0] core_div;

  assign cfg.cfg_ready = (state_q == IDLE) | ~pend_q;
  assign hs            = cfg.cfg_valid & cfg.cfg_ready;
  assign busy          = (state_q != IDLE);
  // Compared before the increment so per_cnt never needs an extra bit.
  assign last_period   = (per_q != '0) && (per_cnt_q + PER_W'(1) == per_q);
  assign core_en       = (state_d != IDLE);
  assign core_div      = CNT_W'(eff_div(32'(div_d)));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    per_d     = per_q;
    div_p_d   = div_p_q;
    per_p_d   = per_p_q;
    pend_d    = pend_q;
    per_cnt_d = per_cnt_q;

    unique case (state_q)
      IDLE: begin
        per_cnt_d = '0;
        pend_d    = 1'b0;
        if (hs) begin
          div_d = cfg.cfg_div;
          per_d = cfg.cfg_periods;
        end else if (pend_q) begin
          // Config accepted on the run's final boundary lands here.
          div_d = div_p_q;
          per_d = per_p_q;
        end
        if (start && !stop) begin
          state_d = RUN;
        end
      end
      RUN, STOPPING: begin
        if (hs) begin
          div_p_d = cfg.cfg_div;
          per_p_d = cfg.cfg_periods;
          pend_d  = 1'b1;
        end
        if (boundary) begin
          // pend_q only reflects handshakes from earlier cycles, so a
          // handshake on this boundary waits for the next one.
          if (pend_q) begin
            div_d     = div_p_q;
            per_d     = per_p_q;
            per_cnt_d = '0;
            pend_d    = 1'b0;
          end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
          end
          if (state_q == STOPPING || stop || last_period) begin
            state_d = IDLE;
          end
        end else if (state_q == RUN && stop) begin
          state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_d = (state_q != IDLE) && (state_d == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= CNT_W'(MIN_DIV);
      per_q     <= '0;
      div_p_q   <= '0;
      per_p_q   <= '0;
      pend_q    <= 1'b0;
      per_cnt_q <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      per_q     <= per_d;
      div_p_q   <= div_p_d;
      per_p_q   <= per_p_d;
      pend_q    <= pend_d;
      per_cnt_q <= per_cnt_d;
      done      <= done_d;
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (core_en),
    .div      (core_div),
    .f_out    (f_out),
    .tick     (tick),
    .boundary (boundary)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl. Each vector row is checked on the falling
// edge, then its inputs are driven for the following rising edge.
// Expected output bits are {f_out, tick, busy, done, cfg_ready}.
module tb_clk_div_ctrl;

  localparam logic [4:0] I = 5'b00001;  // idle
  localparam logic [4:0] D = 5'b00011;  // done cycle

  typedef struct {
    logic        start;
    logic        stop;
    logic        valid;
    logic [15:0] div;
    logic [15:0] per;
    logic [4:0]  exp;
  } vec_t;

  logic clk;
  logic rst;
  logic start, stop;
  logic f_out, tick, busy, done;
  vec_t vecs[$];
  int   checks;
  int   errors;

  clk_div_ctrl_if #(.CNT_W(16), .PER_W(16)) cfg_if ();

  clk_div_ctrl #(
    .CNT_W(16),
    .PER_W(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cfg   (cfg_if),
    .start (start),
    .stop  (stop),
    .f_out (f_out),
    .tick  (tick),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {f_out, tick, busy, done, cfg_if.cfg_ready};
  endfunction

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic v, input int d, input int p,
                     input logic [4:0] e);
    vec_t r;
    r.start = st;
    r.stop  = sp;
    r.valid = v;
    r.div   = 16'(d);
    r.per   = 16'(p);
    r.exp   = e;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic st, input logic sp, input logic v, input logic [15:0] d,
                       input logic [15:0] p);
    start              = st;
    stop               = sp;
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_div     = d;
    cfg_if.cfg_periods = p;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive(0, 0, 0, 16'd0, 16'd0);

    // Counted run: div=4, 3 periods.
    add(0, 0, 1, 4, 3, I);
    add(1, 0, 0, 0, 0, I);
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 0, 0, 0, 5'b11101);
      add(0, 0, 0, 0, 0, 5'b10101);
      add(0, 0, 0, 0, 0, 5'b00101);
      add(0, 0, 0, 0, 0, 5'b00101);
    end
    add(0, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, I);

    // Stop in cycle 7 of a free-running div=5.
    add(0, 0, 1, 5, 0, I);
    add(1, 0, 0, 0, 0, I);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b10101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 1, 0, 0, 0, 5'b10101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, I);

    // Reconfig mid-period div 4 -> 2, second offer held off, then -> 3.
    add(0, 0, 1, 4, 0, I);
    add(1, 0, 0, 0, 0, I);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 1, 2, 0, 5'b10101);
    add(0, 0, 1, 3, 0, 5'b00100);
    add(0, 0, 1, 3, 0, 5'b00100);
    add(0, 0, 1, 3, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b00100);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 1, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, I);

    // Clamp div=0, 2 periods.
    add(0, 0, 1, 0, 2, I);
    add(1, 0, 0, 0, 0, I);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, I);

    // Clamp div=1, start held through done: back-to-back runs.
    add(0, 0, 1, 1, 2, I);
    add(1, 0, 0, 0, 0, I);
    add(1, 0, 0, 0, 0, 5'b11101);
    add(1, 0, 0, 0, 0, 5'b00101);
    add(1, 0, 0, 0, 0, 5'b11101);
    add(1, 0, 0, 0, 0, 5'b00101);
    add(1, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, I);

    // start&stop together, then stop alone, in IDLE.
    add(1, 1, 0, 0, 0, I);
    add(0, 1, 0, 0, 0, I);
    add(0, 0, 0, 0, 0, I);

    // Handshake on a boundary (div 4 -> 2 one period later), stop on a boundary.
    add(0, 0, 1, 4, 0, I);
    add(1, 0, 0, 0, 0, I);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 0, 0, 5'b10101);
    add(0, 0, 0, 0, 0, 5'b00101);
    add(0, 0, 1, 2, 0, 5'b00101);
    add(0, 0, 0, 0, 0, 5'b11100);
    add(0, 0, 0, 0, 0, 5'b10100);
    add(0, 0, 0, 0, 0, 5'b00100);
    add(0, 0, 0, 0, 0, 5'b00100);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(0, 1, 0, 0, 0, 5'b00101);
    add(0, 0, 0, 0, 0, D);
    add(0, 0, 0, 0, 0, I);

    #1;
    chk("reset_state", outs(), I);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      drive(vecs[i].start, vecs[i].stop, vecs[i].valid, vecs[i].div, vecs[i].per);
    end

    // Asynchronous reset mid-run with a config pending.
    @(negedge clk);
    drive(0, 0, 1, 16'd6, 16'd0);
    @(negedge clk);
    drive(1, 0, 0, 16'd0, 16'd0);
    @(negedge clk);
    chk("h_run", outs(), 5'b11101);
    drive(0, 0, 1, 16'd3, 16'd0);
    @(negedge clk);
    drive(0, 0, 0, 16'd0, 16'd0);
    chk("h_pend", outs(), 5'b10100);
    rst = 1'b0;
    #1;
    chk("h_async_rst", outs(), I);
    @(negedge clk);
    chk("h_rst_hold", outs(), I);
    rst   = 1'b1;
    start = 1'b1;

    // Run without config must use the reset ratio of 2.
    @(negedge clk);
    start = 1'b0;
    chk("h_div2_c1", outs(), 5'b11101);
    @(negedge clk);
    chk("h_div2_c2", outs(), 5'b00101);
    @(negedge clk);
    chk("h_div2_c3", outs(), 5'b11101);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("h_stopping", outs(), 5'b00101);
    for (int n = 0; n < 8 && !done; n++) @(negedge clk);
    chk("h_done_wait", {4'b0, done}, 5'b00001);
    @(negedge clk);
    chk("h_final_idle", outs(), I);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
